// File: rtl/cpu_control_unit.sv
// Main decoder and condition checker for the MiniMicro single-cycle datapath.
// Produces registered datapath controls from opcode, condition field and ALU flags.
module cpu_control_unit #(
    parameter int word_size   = 32,
    parameter int opcode_size = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [word_size-1:0]   instruction,
    input  logic [3:0]             flags,
    output logic                   mem_to_reg,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic [opcode_size-1:0] alu_ctrl,
    output logic                   alu_src,
    output logic                   imm_src
);

    localparam logic [opcode_size-1:0] alu_add = opcode_size'(6);
    localparam logic [opcode_size-1:0] op_load = opcode_size'(5'h13);
    localparam logic [opcode_size-1:0] op_store = opcode_size'(5'h14);

    logic [opcode_size-1:0] opcode;
    logic [3:0]             cond;
    logic                   n, z, c, v;
    logic                   cond_ok;
    logic                   is_alu, is_load, is_store, is_imm;

    logic                   d_mem_to_reg, d_mem_write, d_reg_write;
    logic [opcode_size-1:0] d_alu_ctrl;
    logic                   d_alu_src, d_imm_src;

    logic                   unused_bits;

    assign opcode = instruction[word_size-1 -: opcode_size];
    assign cond   = instruction[word_size-opcode_size-1 -: 4];
    assign unused_bits = ^instruction[word_size-opcode_size-5:0];

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    // Opcode classes; bit 4 clear covers the register ALU ops, 11xxx the immediates
    assign is_alu   = !opcode[opcode_size-1] && (opcode != '0);
    assign is_load  = (opcode == op_load);
    assign is_store = (opcode == op_store);
    assign is_imm   = (opcode[opcode_size-1 -: 2] == 2'b11);

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = 1'b1;
            4'h1: cond_ok = z;
            4'h2: cond_ok = !z;
            4'h3: cond_ok = c;
            4'h4: cond_ok = !c;
            4'h5: cond_ok = n;
            4'h6: cond_ok = !n;
            4'h7: cond_ok = v;
            4'h8: cond_ok = !v;
            4'h9: cond_ok = c && !z;
            4'hA: cond_ok = !c || z;
            4'hB: cond_ok = (n == v);
            4'hC: cond_ok = (n != v);
            4'hD: cond_ok = !z && (n == v);
            4'hE: cond_ok = z || (n != v);
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        d_mem_to_reg = 1'b0;
        d_mem_write  = 1'b0;
        d_reg_write  = 1'b0;
        d_alu_ctrl   = '0;
        d_alu_src    = 1'b0;
        d_imm_src    = 1'b0;
        unique case (1'b1)
            is_alu: begin
                d_reg_write = 1'b1;
                d_alu_ctrl  = opcode;
            end
            is_load: begin
                d_reg_write  = 1'b1;
                d_mem_to_reg = 1'b1;
                d_alu_src    = 1'b1;
                d_alu_ctrl   = alu_add;
            end
            is_store: begin
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_alu_ctrl  = alu_add;
            end
            is_imm: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm_src   = 1'b1;
                d_alu_ctrl  = opcode_size'(opcode[2:0]);
            end
            default: ;
        endcase
    end

    // A failed condition squashes the whole instruction to a NOP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            alu_ctrl   <= '0;
            alu_src    <= 1'b0;
            imm_src    <= 1'b0;
        end else if (cond_ok) begin
            mem_to_reg <= d_mem_to_reg;
            mem_write  <= d_mem_write;
            reg_write  <= d_reg_write;
            alu_ctrl   <= d_alu_ctrl;
            alu_src    <= d_alu_src;
            imm_src    <= d_imm_src;
        end else begin
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            alu_ctrl   <= '0;
            alu_src    <= 1'b0;
            imm_src    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit.
// Outputs are compared as {mem_to_reg, mem_write, reg_write, alu_ctrl, alu_src, imm_src}.
module tb_cpu_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [3:0]  flags;
    logic        mem_to_reg, mem_write, reg_write, alu_src, imm_src;
    logic [4:0]  alu_ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_control_unit #(.word_size(32), .opcode_size(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .flags       (flags),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .imm_src     (imm_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {mem_to_reg, mem_write, reg_write, alu_ctrl, alu_src, imm_src};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Present inputs after a falling edge, sample 1 time unit after the next rising edge
    task automatic apply(input string tag, input logic [31:0] ins,
                         input logic [3:0] fl, input logic [9:0] exp);
        @(negedge clk);
        instruction = ins;
        flags = fl;
        @(posedge clk);
        #1;
        check(tag, outs(), exp);
    endtask

    localparam logic [9:0] ZERO  = 10'b0000000000;
    localparam logic [9:0] LOAD  = 10'b1010011010;
    localparam logic [9:0] ADD   = 10'b0010011000;
    localparam logic [9:0] STORE = 10'b0100011010;
    localparam logic [9:0] IMM6  = 10'b0010011011;
    localparam logic [9:0] ALU15 = 10'b0010111100;
    localparam logic [9:0] ALU1  = 10'b0010000100;
    localparam logic [9:0] IMM0  = 10'b0010000011;

    initial begin
        rst = 1'b0;
        instruction = 32'h9800_0000;
        flags = 4'h0;
        #1;
        check("reset_t0", outs(), ZERO);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_edge", outs(), ZERO);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_load", outs(), LOAD);

        apply("load",        32'h9800_0000, 4'h0, LOAD);
        apply("add",         32'h3000_0202, 4'h0, ADD);
        apply("nop",         32'h0000_0000, 4'h0, ZERO);
        apply("alu_0x0f",    32'h7800_0000, 4'h0, ALU15);
        apply("alu_0x01",    32'h0800_0000, 4'hF, ALU1);
        apply("store_eq_t",  32'hA080_0000, 4'b0100, STORE);
        apply("store_eq_f",  32'hA080_0000, 4'b0000, ZERO);
        apply("add_gt_t",    32'h3680_0000, 4'b1001, ADD);
        apply("add_gt_z",    32'h3680_0000, 4'b1101, ZERO);
        apply("add_nv",      32'h3780_0000, 4'b0000, ZERO);
        apply("add_nv_all",  32'h3780_0000, 4'b1111, ZERO);
        apply("add_hi_t",    32'h3480_0000, 4'b0010, ADD);
        apply("add_hi_f",    32'h3480_0000, 4'b0110, ZERO);
        apply("add_lt_t",    32'h3600_0000, 4'b1000, ADD);
        apply("add_lt_f",    32'h3600_0000, 4'b1001, ZERO);
        apply("add_ne_t",    32'h3100_0000, 4'b0000, ADD);
        apply("add_le_z",    32'h3700_0000, 4'b0100, ADD);
        apply("add_vc_f",    32'h3400_0000, 4'b0001, ZERO);
        apply("imm_0x1e",    32'hF000_0000, 4'h0, IMM6);
        apply("imm_0x18",    32'hC000_0000, 4'h0, IMM0);
        apply("undef_0x15",  32'hA800_0000, 4'h0, ZERO);
        apply("undef_0x10",  32'h8000_0000, 4'h0, ZERO);
        apply("undef_0x17",  32'hB800_0000, 4'h0, ZERO);
        apply("load_again",  32'h9800_0000, 4'h0, LOAD);

        // Asynchronous clear between edges
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", outs(), ZERO);
        @(posedge clk);
        #1;
        check("held_in_reset", outs(), ZERO);
        @(negedge clk);
        rst = 1'b1;
        instruction = 32'hF000_0000;
        @(posedge clk);
        #1;
        check("post_reset_imm", outs(), IMM6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
